// File: rtl/jt12_wrq.sv
// jt12_wrq: shares one jt12 bus port between two requesters through a write FIFO.
// Optional bounded busy wait with timeout pulse: define JT12_WRQ_TIMEOUT_EN.
module jt12_wrq #(
  parameter int DEPTH      = 8,
  parameter int STROBE_LEN = 2,
  parameter int GAP        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic                     a_valid,
  input  logic [1:0]               a_addr,
  input  logic [7:0]               a_din,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [1:0]               b_addr,
  input  logic [7:0]               b_din,
  output logic                     b_ready,
  output logic [1:0]               ym_addr,
  output logic [7:0]               ym_din,
  output logic                     ym_cs_n,
  output logic                     ym_wr_n,
  input  logic                     ym_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     timeout
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (STROBE_LEN > GAP) ? STROBE_LEN : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP, S_WAIT} state_t;

  // Arbiter state; owner/rr use 0 for A and 1 for B.
  logic lock_q, lock_d, owner_q, owner_d, rr_q, rr_d;
  logic grant_a, grant_b, src, push, pop, full, empty;
  logic [1:0] push_addr;
  logic [7:0] push_din;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [9:0]    head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_n_q, cs_n_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    din_q, din_d;

  always_comb begin
    if (lock_q) begin
      grant_a = a_valid & ~owner_q;
      grant_b = b_valid & owner_q;
    end else begin
      grant_a = a_valid & (~b_valid | ~rr_q);
      grant_b = b_valid & ~grant_a;
    end
  end

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign a_ready   = ~full & grant_a;
  assign b_ready   = ~full & grant_b;
  assign push      = (a_valid & a_ready) | (b_valid & b_ready);
  assign src       = grant_b;
  assign push_addr = src ? b_addr : a_addr;
  assign push_din  = src ? b_din : a_din;

  // An address write opens a pair; the owner's data write closes it.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (push) begin
      rr_d = ~src;
      if (!push_addr[0]) begin
        lock_d  = 1'b1;
        owner_d = src;
      end else if (lock_q && (owner_q == src)) begin
        lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {push_addr, push_din};
  end

  assign head = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef JT12_WRQ_TIMEOUT_EN
  logic [9:0] wcnt_q, wcnt_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    addr_d  = addr_q;
    din_d   = din_q;
    pop     = 1'b0;
`ifdef JT12_WRQ_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    timeout_d = 1'b0;
`endif
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop             = 1'b1;
            {addr_d, din_d} = head;
            cs_n_d          = 1'b0;
            cnt_d           = CW'(STROBE_LEN - 1);
            state_d         = S_STROBE;
          end
        end
        S_STROBE: begin
          if (cnt_q == '0) begin
            cs_n_d  = 1'b1;
            cnt_d   = CW'(GAP - 1);
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = addr_q[0] ? S_WAIT : S_IDLE;
`ifdef JT12_WRQ_TIMEOUT_EN
            wcnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (!ym_busy) begin
            state_d = S_IDLE;
`ifdef JT12_WRQ_TIMEOUT_EN
          end else if (wcnt_q == 10'd1023) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 10'd1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

`ifdef JT12_WRQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign ym_addr = addr_q;
  assign ym_din  = din_q;
  assign ym_cs_n = cs_n_q;
  assign ym_wr_n = cs_n_q;
  assign level   = count_q;

endmodule

// File: tb/tb_jt12_wrq.sv
// Bench for jt12_wrq: requester queues, a scoreboard of accepted writes and
// cen-tick accounting of strobe and gap lengths.
module tb_jt12_wrq;
  localparam int DEPTH = 8, STROBE_LEN = 2, GAP = 4;

  logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0, ym_busy = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_ready, b_ready, ym_cs_n, ym_wr_n, timeout;
  logic [1:0] ym_addr;
  logic [7:0] ym_din;
  logic [3:0] level;

  jt12_wrq #(.DEPTH(DEPTH), .STROBE_LEN(STROBE_LEN), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .a_valid(a_valid), .a_addr(a_addr), .a_din(a_din), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_din(b_din), .b_ready(b_ready),
    .ym_addr(ym_addr), .ym_din(ym_din), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
    .ym_busy(ym_busy), .level(level), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int cen_mode = 0, busy_mode = 0;
  int lo_ticks = 0, hi_ticks = 0, timeout_pulses = 0;
  bit seen_rise = 0;
  bit m_lock = 0, m_owner = 0, m_rr = 0;
  logic [9:0] a_q[$], b_q[$], mq[$], xfer_word[$];
  bit xfer_src[$];
  int fall_cyc[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rand_word(bit force_data);
    logic [9:0] w;
    w = 10'($urandom);
    if (force_data) w[8] = 1'b1;
    return w;
  endfunction

  // Who the arbitration rules allow to transfer this clk.
  function automatic void exp_grants(output bit ga, output bit gb);
    bit room;
    room = (mq.size() < DEPTH);
    ga = 0;
    gb = 0;
    if (m_lock) begin
      if (m_owner) gb = b_valid; else ga = a_valid;
    end else if (a_valid && b_valid) begin
      if (m_rr) gb = 1; else ga = 1;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
    ga = ga && room;
    gb = gb && room;
  endfunction

  function automatic void accept(bit s, logic [9:0] w);
    mq.push_back(w);
    xfer_word.push_back(w);
    xfer_src.push_back(s);
    if (!w[8]) begin
      m_lock = 1;
      m_owner = s;
    end else if (m_lock && m_owner == s) begin
      m_lock = 0;
    end
    m_rr = !s;
  endfunction

  task automatic tick();
    bit ga, gb, cs_before, cen_edge, fall, rise;
    logic [9:0] e;
    case (cen_mode)
      0: cen = 1'b1;
      1: cen = ($urandom_range(0, 3) != 0);
      default: cen = 1'b0;
    endcase
    case (busy_mode)
      0: ym_busy = 1'b0;
      1: ym_busy = 1'($urandom_range(0, 1));
      2: ym_busy = 1'b1;
      default: ;
    endcase
    a_valid = (a_q.size() > 0);
    if (a_valid) {a_addr, a_din} = a_q[0];
    b_valid = (b_q.size() > 0);
    if (b_valid) {b_addr, b_din} = b_q[0];
    #2;
    exp_grants(ga, gb);
    check("a_xfer", 32'(a_valid & a_ready), 32'(ga));
    check("b_xfer", 32'(b_valid & b_ready), 32'(gb));
    cs_before = ym_cs_n;
    cen_edge  = cen;
    @(posedge clk);
    #1;
    cyc++;
    fall = cs_before && !ym_cs_n;
    rise = !cs_before && ym_cs_n;
    if (cen_edge) begin
      if (cs_before) hi_ticks++; else lo_ticks++;
    end
    if (fall) begin
      if (mq.size() == 0) check("pop_underflow", 32'(1), 32'(0));
      else begin
        e = mq.pop_front();
        check("ym_word", 32'({ym_addr, ym_din}), 32'(e));
      end
      if (seen_rise) check("gap_ticks_ok", 32'(hi_ticks >= GAP + 1), 32'(1));
      fall_cyc.push_back(cyc);
      lo_ticks = 0;
    end
    if (rise) begin
      check("strobe_ticks", 32'(lo_ticks), 32'(STROBE_LEN));
      hi_ticks = 0;
      seen_rise = 1;
    end
    if (ga) accept(0, a_q.pop_front());
    if (gb) accept(1, b_q.pop_front());
    check("level", 32'(level), 32'(mq.size()));
    check("wr_n_eq_cs_n", 32'(ym_wr_n), 32'(ym_cs_n));
`ifdef JT12_WRQ_TIMEOUT_EN
    if (timeout === 1'b1) timeout_pulses++;
`else
    check("timeout_off", 32'(timeout), 32'(0));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_q.delete(); b_q.delete(); mq.delete();
    m_lock = 0; m_owner = 0; m_rr = 0;
    seen_rise = 0; lo_ticks = 0; hi_ticks = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    fall_cyc.delete(); xfer_src.delete(); xfer_word.delete();
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || mq.size() > 0) && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < bound), 32'(1));
  endtask

  task automatic settle(int n);
    cen_mode = 0;
    busy_mode = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int f0;
    // reset values
    do_reset();
    check("rst_cs_n", 32'(ym_cs_n), 32'(1));
    check("rst_wr_n", 32'(ym_wr_n), 32'(1));
    check("rst_addr", 32'(ym_addr), 32'(0));
    check("rst_din", 32'(ym_din), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    a_valid = 1'b1;
    #1;
    check("rst_a_ready", 32'(a_ready), 32'(1));
    check("rst_b_ready", 32'(b_ready), 32'(0));
    a_valid = 1'b0;

    // single pair, busy high over the data write, then a third data write
    cen_mode = 0;
    busy_mode = 3;
    a_q = '{10'h028, 10'h1F0, 10'h155};
    for (int c = 1; c <= 40; c++) begin
      ym_busy = (c >= 9 && c <= 20);
      tick();
    end
    check("pair_strobes", 32'(fall_cyc.size()), 32'(3));
    if (fall_cyc.size() == 3) begin
      check("addr_strobe_cyc", 32'(fall_cyc[0]), 32'(2));
      check("data_strobe_cyc", 32'(fall_cyc[1]), 32'(9));
      check("after_wait_cyc", 32'(fall_cyc[2]), 32'(22));
    end

    // pair atomicity
    do_reset();
    cen_mode = 0;
    busy_mode = 0;
    a_q.push_back(10'h030);
    tick();
    b_q.push_back(10'h1C3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_locked_out", 32'(b_ready), 32'(0));
    end
    a_q.push_back(10'h1AB);
    drain(200);
    settle(10);
    check("atom_count", 32'(xfer_word.size()), 32'(3));
    if (xfer_word.size() == 3) begin
      check("atom_0", 32'(xfer_word[0]), 32'(10'h030));
      check("atom_1", 32'(xfer_word[1]), 32'(10'h1AB));
      check("atom_2", 32'(xfer_word[2]), 32'(10'h1C3));
    end

    // round robin on unlocked data writes
    do_reset();
    cen_mode = 1;
    busy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      a_q.push_back(rand_word(1));
      b_q.push_back(rand_word(1));
    end
    drain(3000);
    settle(12);
    check("rr_count", 32'(xfer_src.size()), 32'(12));
    for (int i = 0; i < xfer_src.size(); i++)
      check("rr_order", 32'(xfer_src[i]), 32'(i % 2));

    // fill to full with the FSM frozen, then drain 20 across the wrap
    cen_mode = 2;
    busy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      a_q.push_back(rand_word(i == 4));
      b_q.push_back(rand_word(i == 4));
    end
    for (int i = 0; i < 10; i++) tick();
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_a_ready", 32'(a_ready), 32'(0));
    check("full_b_ready", 32'(b_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      a_q.push_back(rand_word(i == 4));
      b_q.push_back(rand_word(i == 4));
    end
    cen_mode = 1;
    busy_mode = 1;
    drain(5000);
    settle(12);
    check("wrap_level", 32'(level), 32'(0));

    // push in the same clk as an IDLE pop
    cen_mode = 2;
    for (int i = 0; i < 3; i++) a_q.push_back(rand_word(1));
    for (int i = 0; i < 3; i++) tick();
    check("pre_simul_level", 32'(level), 32'(3));
    a_q.push_back(rand_word(1));
    cen_mode = 0;
    n = fall_cyc.size();
    tick();
    check("simul_level", 32'(level), 32'(3));
    check("simul_pop", 32'(fall_cyc.size()), 32'(n + 1));
    drain(500);
    settle(12);

    // reset in the middle of a strobe
    cen_mode = 1;
    a_q = '{10'h0B4, 10'h1C0};
    b_q = '{10'h355};
    n = 0;
    while (ym_cs_n !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check("strobe_seen", 32'(ym_cs_n), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(ym_cs_n), 32'(1));
    check("midrst_wr_n", 32'(ym_wr_n), 32'(1));
    check("midrst_level", 32'(level), 32'(0));
    do_reset();
    cen_mode = 0;
    b_q.push_back(10'h1EE);
    tick();
    check("unlocked_b", 32'(xfer_src.size()), 32'(1));
    drain(200);
    settle(12);

`ifdef JT12_WRQ_TIMEOUT_EN
    // busy stuck high: bounded wait, then the next entry issues
    cen_mode = 0;
    busy_mode = 2;
    timeout_pulses = 0;
    n = fall_cyc.size();
    a_q = '{10'h1AA, 10'h0BB};
    tick();
    tick();
    f0 = (fall_cyc.size() > n) ? fall_cyc[n] : 0;
    n = 0;
    while (timeout_pulses == 0 && n < 1200) begin
      tick();
      n++;
    end
    check("timeout_seen", 32'(timeout_pulses), 32'(1));
    check("timeout_window", 32'(cyc - f0 >= STROBE_LEN + GAP + 1023 &&
                                cyc - f0 <= STROBE_LEN + GAP + 1024), 32'(1));
    tick();
    check("timeout_one_clk", 32'(timeout), 32'(0));
    check("next_after_timeout", 32'(mq.size()), 32'(0));
    drain(100);
    settle(12);
`else
    f0 = 0;
    check("timeout_tied", 32'(timeout), 32'(f0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt12_wrq.md
# jt12_wrq

Write-queue scheduler for the jt12 FM core's 4-byte bus port. It lets two requesters share one jt12 instance, typically the 68k and the Z80 on Genesis. It arbitrates between them with address/data pair locking, buffers accepted writes in a FIFO, and issues them to the core with cen-paced cs_n/wr_n strobes. After every data write it waits for the core's busy flag to drop before issuing the next write.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- STROBE_LEN, 2: cen ticks for which cs_n/wr_n are held low per write; at least 1.
- GAP, 4: cen ticks waited after each strobe before busy is sampled; at least 1.

Ports:
- clk  in  1  system clock, the same clock as jt12.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cen  in  1  clock enable shared with jt12; paces the issue FSM only.
- a_valid, a_addr[1:0], a_din[7:0]  in  1/2/8  requester A write offer.
- a_ready  out  1  A transfer occurs when a_valid & a_ready.
- b_valid, b_addr[1:0], b_din[7:0]  in  1/2/8  requester B write offer.
- b_ready  out  1  B transfer occurs when b_valid & b_ready.
- ym_addr  out  2  to jt12 addr.
- ym_din  out  8  to jt12 din.
- ym_cs_n, ym_wr_n  out  1  to jt12 cs_n, wr_n.
- ym_busy  in  1  jt12 dout[7].
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- timeout  out  1  one-clk pulse on busy timeout; tied 0 when the timeout feature is compiled out.

## Operation
- Arbiter runs every clk, independent of cen. State: lock (1b), owner (1b), rr (1b).
- Unlocked:
  - grant = A if a_valid & (!b_valid | rr==A); otherwise grant = B if b_valid.
  - After a transfer, rr points to the other requester.
- Locked: only owner may be granted.
- a_ready = !full & grant==A. b_ready is symmetric. At most one push per clk.
- Locking on a transfer:
  - addr[0]==0 (register address write): set lock, owner = source.
  - addr[0]==1 (data write) by owner: clear lock.
  - A further address write by owner keeps the lock.
- FIFO entry is {addr[1:0], din[7:0]}. Pushes from the arbiter and pops from the FSM may occur in the same clk; level is unchanged in that case.
- Issue FSM advances only on clk edges where cen=1:
  - IDLE: if FIFO non-empty, pop the head, load ym_addr/ym_din, assert ym_cs_n=ym_wr_n=0, load cnt=STROBE_LEN-1, go to STROBE.
  - STROBE: at cnt==0, deassert cs_n/wr_n, load cnt=GAP-1, go to GAP; otherwise decrement cnt.
  - GAP: at cnt==0, go to WAIT if the issued addr[0]==1, else IDLE; otherwise decrement.
  - WAIT: when ym_busy==0, go to IDLE.
- ym_addr/ym_din hold their last value outside STROBE.

## Timing
- Reset values:
  - ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0.
  - FSM=IDLE; FIFO empty, level=0.
  - lock=0, rr=A, timeout=0.
  - a_ready/b_ready follow the combinational rule above, so they can be 1 right after reset.
- Push at clk N is visible to the FSM from clk N+1. The strobe starts on the first cen edge at or after N+1.
- Each write occupies exactly STROBE_LEN cen ticks of strobe and GAP cen ticks of gap. Data writes add WAIT time.
- full: both readies are 0. A write held off while full is not lost; the requester keeps valid high.
- empty: the FSM stays in IDLE and outputs do not toggle.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-strobe: ym_cs_n/ym_wr_n return to 1 immediately (asynchronously), the FIFO is discarded, and the lock is cleared.
- cen low: the FSM freezes, the strobe is held, and the FIFO still accepts pushes.

## Configuration
- JT12_WRQ_TIMEOUT_EN defined:
  - A 10-bit counter of cen ticks spent in WAIT.
  - At 1023, the FSM goes to IDLE and timeout pulses for one clk.
  - The counter clears on entering WAIT.
- Undefined: WAIT has no bound, and timeout is constant 0.

## Test plan
- Single pair: A pushes {0,0x28} then {1,0xF0}, with cen=1 and busy modelled low 3 cycles after the data strobe. Required: two strobes, each 2 cen wide, order addr 0 then 1; data 0x28 then 0xF0; the FSM waits for busy low before returning to IDLE.
- Pair atomicity: A pushes addr write 0x30, then B and A both hold valid. Required: B stays not ready until A's data write transfers, and the FIFO order is A-addr, A-data, B.
- Round-robin: A and B continuously offer data writes (addr[0]=1), unlocked. Required: transfers alternate A, B, A, B, starting with A after reset.
- Full/wrap: push 8 entries with busy held high. Required: level=8, both ready=0. Then release busy and drain 20 entries. Required: pops occur in exact FIFO order, and level returns to 0 after pointer wrap.
- Simultaneous push/pop: with level=3, push in the same clk as an IDLE pop. Required: level stays 3.
- Reset mid-strobe and timeout: drop rst_n during STROBE. Required: cs_n/wr_n=1 immediately and level=0. With JT12_WRQ_TIMEOUT_EN and busy stuck high, a data write must produce a timeout pulse after 1023 cen ticks in WAIT, and the next entry must then issue.
